// File: rtl/alu_iter_exec_if.sv
// alu_iter_exec_if: request/response bundle between the pipeline and the iterative ALU
//   start_i/flush_i/ALUOp_i/funct_i/data1_i/data2_i : pipeline -> ALU
//   ALUCtrl_o/result_o/done_o/busy_o/illegal_o/dz_o : ALU -> pipeline
interface alu_iter_exec_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic             flush_i;
  logic [1:0]       ALUOp_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [2:0]       ALUCtrl_o;
  logic [WIDTH-1:0] result_o;
  logic             done_o;
  logic             busy_o;
  logic             illegal_o;
  logic             dz_o;
  modport master (
    output start_i, flush_i, ALUOp_i, funct_i, data1_i, data2_i,
    input  ALUCtrl_o, result_o, done_o, busy_o, illegal_o, dz_o
  );
  modport slave (
    input  start_i, flush_i, ALUOp_i, funct_i, data1_i, data2_i,
    output ALUCtrl_o, result_o, done_o, busy_o, illegal_o, dz_o
  );
endinterface

// File: rtl/alu_iter_exec.sv
// alu_iter_exec: ALU control decode plus execution, add/sub/and/or in one cycle, mul/divu iterative
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-low reset
//   bus   : alu_iter_exec_if slave (request inputs, result/done/busy/illegal/dz outputs)
module alu_iter_exec #(
  parameter int WIDTH      = 32,
  parameter bit ENABLE_DIV = 1'b1
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_iter_exec_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d, result_q, result_d;
  logic             done_q, done_d, illegal_q, illegal_d, dz_q, dz_d;
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] mul_acc, div_rem, div_quo, alu_res;
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;
  always_comb begin
    ctrl = 3'b111;
    case (bus.ALUOp_i)
      2'b00: ctrl = 3'b010;
      2'b01: ctrl = 3'b110;
      2'b10: ctrl = 3'b001;
      default:
        case (bus.funct_i)
          6'b100000: ctrl = 3'b010;
          6'b100010: ctrl = 3'b110;
          6'b100100: ctrl = 3'b000;
          6'b100101: ctrl = 3'b001;
          6'b011000: ctrl = 3'b011;
          6'b011010: ctrl = ENABLE_DIV ? 3'b100 : 3'b111;
          default:   ctrl = 3'b111;
        endcase
    endcase
  end
  assign alu_res = ctrl == 3'b010 ? bus.data1_i + bus.data2_i :
                   ctrl == 3'b110 ? bus.data1_i - bus.data2_i :
                   ctrl == 3'b000 ? bus.data1_i & bus.data2_i :
                   ctrl == 3'b001 ? bus.data1_i | bus.data2_i : '0;
  // mul: acc = product, a = shifted multiplicand, b = shifted multiplier
  assign mul_acc = acc_q + (b_q[0] ? a_q : '0);
  // divu: acc = partial remainder, a = dividend shifting out / quotient shifting in, b = divisor
  // a zero divisor always "fits", which yields the all-ones quotient
  assign rem_sh  = {acc_q, a_q[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, b_q};
  assign ge      = ~diff[WIDTH] | ~|b_q;
  assign div_rem = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_quo = {a_q[WIDTH-2:0], ge};
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    dz_d      = 1'b0;
    if (bus.flush_i) state_d = IDLE;
    else
      case (state_q)
        IDLE:
          if (bus.start_i) begin
            acc_d = '0;
            a_d   = bus.data1_i;
            b_d   = bus.data2_i;
            cnt_d = CW'(WIDTH - 1);
            case (ctrl)
              3'b011: state_d = MUL;
              3'b100: state_d = DIV;
              default: begin
                done_d    = 1'b1;
                illegal_d = ctrl == 3'b111;
                result_d  = alu_res;
              end
            endcase
          end
        MUL: begin
          acc_d = mul_acc;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d  = IDLE;
            cnt_d    = '0;
            done_d   = 1'b1;
            result_d = mul_acc;
          end
        end
        DIV: begin
          acc_d = div_rem;
          a_d   = div_quo;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d  = IDLE;
            cnt_d    = '0;
            done_d   = 1'b1;
            dz_d     = ~|b_q;
            result_d = div_quo;
          end
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      dz_q      <= dz_d;
    end
  end
  assign bus.ALUCtrl_o = ctrl;
  assign bus.result_o  = result_q;
  assign bus.done_o    = done_q;
  assign bus.busy_o    = state_q != IDLE;
  assign bus.illegal_o = illegal_q;
  assign bus.dz_o      = dz_q;
endmodule

// File: tb/tb_alu_iter_exec.sv
// tb_alu_iter_exec: scoreboard bench driving three ALU configurations from one stimulus stream
module tb_alu_iter_exec;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [5:0]  fn = 6'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        ending = 1'b0;
  event        rst_ev, dec_ev;
  int          checks = 0, passes = 0;
  typedef struct {logic [31:0] res; logic ill; logic dz; int cyc;} exp_t;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_MUL = 6'h18, F_DIV = 6'h1a;
  always #5 clk = ~clk;
  function automatic logic [2:0] ref_ctrl(input logic [1:0] o, input logic [5:0] f, input bit en);
    if (o == 2'd0) return 3'b010;
    if (o == 2'd1) return 3'b110;
    if (o == 2'd2) return 3'b001;
    case (f)
      F_ADD:   return 3'b010;
      F_SUB:   return 3'b110;
      F_AND:   return 3'b000;
      F_OR:    return 3'b001;
      F_MUL:   return 3'b011;
      F_DIV:   return en ? 3'b100 : 3'b111;
      default: return 3'b111;
    endcase
  endfunction
  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s inst%0d: got %h expected %h", nm, g, act, exp);
  endtask
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int W = (g == 1) ? 8 : 32;
    localparam bit D = (g != 2);
    localparam logic [31:0] M = (W == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    alu_iter_exec_if #(.WIDTH(W)) bus ();
    alu_iter_exec #(.WIDTH(W), .ENABLE_DIV(D)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus.slave));
    assign bus.start_i = start;
    assign bus.flush_i = flush;
    assign bus.ALUOp_i = op;
    assign bus.funct_i = fn;
    assign bus.data1_i = a[W-1:0];
    assign bus.data2_i = b[W-1:0];
    exp_t        q[$];
    exp_t        e;
    int          inflight = 0, ncyc = 0;
    logic [31:0] last = 32'd0;
    logic [2:0]  mc;
    logic [63:0] mx, my, mr;
    logic        mi, mdz;
    bit          iter;
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        inflight = 0;
      end else begin
        ncyc++;
        if (flush) begin
          if (inflight > 0) void'(q.pop_back());
          inflight = 0;
        end else if (inflight > 0) inflight--;
        else if (start) begin
          mc = ref_ctrl(op, fn, D);
          mx = 64'(a & M);
          my = 64'(b & M);
          mi = 1'b0;
          mdz = 1'b0;
          case (mc)
            3'b010: mr = mx + my;
            3'b110: mr = mx - my;
            3'b000: mr = mx & my;
            3'b001: mr = mx | my;
            3'b011: mr = mx * my;
            3'b100: begin
              mdz = (my == 64'd0);
              mr = mdz ? 64'(M) : mx / my;
            end
            default: begin
              mr = 64'd0;
              mi = 1'b1;
            end
          endcase
          iter = (mc == 3'b011) || (mc == 3'b100);
          q.push_back('{32'(mr) & M, mi, mdz, ncyc + (iter ? W : 0)});
          inflight = iter ? W : 0;
        end
      end
    end
    initial forever begin
      @(negedge clk);
      if (!rst_n) last = 32'd0;
      else begin
        chk("busy", g, 32'(bus.busy_o), 32'(inflight > 0));
        if (bus.done_o) begin
          chk("done_expected", g, 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("result", g, 32'(bus.result_o), e.res);
            chk("flags", g, {30'd0, bus.illegal_o, bus.dz_o}, {30'd0, e.ill, e.dz});
            chk("latency", g, ncyc, e.cyc);
            last = e.res;
          end
        end else begin
          chk("idle_flags", g, {30'd0, bus.illegal_o, bus.dz_o}, 32'd0);
          chk("hold", g, 32'(bus.result_o), last);
        end
      end
    end
    initial forever begin
      @(rst_ev);
      chk("rst_result", g, 32'(bus.result_o), 32'd0);
      chk("rst_ctl", g, {28'd0, bus.done_o, bus.busy_o, bus.illegal_o, bus.dz_o}, 32'd0);
    end
    initial forever begin
      @(dec_ev);
      chk("decode", g, 32'(bus.ALUCtrl_o), 32'(ref_ctrl(op, fn, D)));
    end
    initial begin
      wait (ending);
      chk("drained", g, q.size(), 0);
    end
  end
  task automatic drive(input logic s, input logic fl, input logic [1:0] o, input logic [5:0] f,
                       input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = s;
    flush = fl;
    op = o;
    fn = f;
    a = x;
    b = y;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 2'($urandom), 6'($urandom), $urandom, $urandom);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction
  logic [5:0] ft[7] = '{F_ADD, F_SUB, F_AND, F_OR, F_MUL, F_DIV, 6'h00};
  initial begin
    repeat (3) @(negedge clk);
    -> rst_ev;
    @(negedge clk);
    rst_n = 1'b1;
    for (int o = 0; o < 4; o++)
      for (int f = 0; f < 64; f++) begin
        @(negedge clk);
        op = 2'(o);
        fn = 6'(f);
        #1 -> dec_ev;
      end
    drive(1, 0, 2'd3, F_ADD, 32'h7FFF_FFFF, 32'd1); idle(2);
    drive(1, 0, 2'd3, F_SUB, 32'd5, 32'd7); idle(2);
    drive(1, 0, 2'd3, F_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    drive(1, 0, 2'd3, F_OR, 32'hF0F0_F0F0, 32'hFF00_FF00); idle(2);
    drive(1, 0, 2'd0, 6'h3F, 32'd9, 32'd4);
    drive(1, 0, 2'd1, 6'h00, 32'd9, 32'd4);
    drive(1, 0, 2'd2, 6'h11, 32'h0F00, 32'h00F0);
    drive(1, 0, 2'd3, 6'h3F, 32'd1, 32'd2); idle(2);
    drive(1, 0, 2'd3, F_MUL, 32'hFFFF_FFFF, 32'd3);
    repeat (5) begin
      drive(1, 0, 2'd3, F_ADD, 32'd1, 32'd2);
      idle(3);
    end
    idle(40);
    drive(1, 0, 2'd3, F_DIV, 32'd100, 32'd7); idle(40);
    drive(1, 0, 2'd3, F_DIV, 32'd5, 32'd0); idle(40);
    drive(1, 0, 2'd3, F_MUL, 32'd12345, 32'd678); idle(9);
    drive(0, 1, 2'd3, F_ADD, 32'd0, 32'd0); idle(40);
    drive(1, 1, 2'd3, F_ADD, 32'd1, 32'd1); idle(3);
    drive(1, 0, 2'd3, F_MUL, 32'h1234, 32'h10);
    repeat (33) drive(1, 0, 2'd3, F_MUL, 32'd6, 32'd7);
    idle(40);
    drive(1, 0, 2'd3, F_MUL, 32'hFF, 32'hFF); idle(40);
    drive(1, 0, 2'd3, F_MUL, 32'd77, 32'd99); idle(5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 -> rst_ev;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2000) begin
      logic [31:0] r;
      r = $urandom;
      drive(r[1:0] != 2'd0, r[7:2] == 6'd0, (r[10:9] == 2'd0) ? r[12:11] : 2'd3,
            (r[15:13] == 3'd7) ? 6'($urandom) : ft[r[15:13] % 7], pick(), pick());
    end
    idle(80);
    ending = 1'b1;
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes ALUOp/funct into an ALU control code and executes the operation.
- Single-cycle ops (add/sub/and/or) complete with 1-cycle latency; MUL and DIVU run iteratively.
- Drives busy_o so the pipeline stall logic can freeze the ID/EX stage while an iterative op is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- ENABLE_DIV, 1, 1 = DIVU supported; 0 = DIVU funct decodes as illegal.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  operation request; sampled only when idle (see Behaviour).
- ALUOp_i  input  2  main-control op class.
- funct_i  input  6  R-type function field.
- data1_i  input  WIDTH  operand A (rs).
- data2_i  input  WIDTH  operand B (rt/imm).
- flush_i  input  1  synchronous abort of the current operation.
- ALUCtrl_o  output  3  combinational decode of ALUOp_i/funct_i.
- result_o  output  WIDTH  registered result, held until next done_o.
- done_o  output  1  one-cycle pulse: result_o valid.
- busy_o  output  1  iterative op in progress.
- illegal_o  output  1  registered with done_o: undecodable op.
- dz_o  output  1  registered with done_o: DIVU by zero.

Behaviour:
- Decode (combinational, always driven, no latches):
  - ALUOp 00 → add 010.
  - ALUOp 01 → sub 110.
  - ALUOp 10 → or 001.
  - ALUOp 11 → by funct: 100000 add 010; 100010 sub 110; 100100 and 000; 100101 or 001; 011000 mul 011; 011010 divu 100 (if ENABLE_DIV).
  - Any other combination → 111 (illegal).
- Reset (rst_i low, async):
  - state = IDLE.
  - result_o = 0; done_o, busy_o, illegal_o, dz_o = 0.
  - Iteration counter and internal accumulators = 0.
  - Reset mid-operation discards the operation; no done_o follows.
- FSM states: IDLE, MUL, DIV.
  - start_i is accepted only in IDLE with flush_i low. start_i in MUL/DIV is ignored (no queueing).
  - Single-cycle op or illegal op accepted at edge N:
    - result_o is updated and done_o = 1 at N+1.
    - FSM stays IDLE.
    - Illegal op: result_o = 0, illegal_o = 1.
  - MUL:
    - Latch A and B at acceptance.
    - Radix-2 shift-add, one bit per cycle, WIDTH iterations.
    - busy_o = 1 for cycles N+1..N+WIDTH.
    - At N+WIDTH+1: done_o = 1, busy_o = 0, result_o = low WIDTH bits of A*B (modulo 2^WIDTH; signed and unsigned agree), state IDLE.
  - DIV (unsigned restoring division): same timing as MUL; result_o = quotient; remainder discarded.
  - B = 0 on DIV: still WIDTH iterations; result_o = all ones, dz_o = 1 with done_o.
  - Back-to-back: start_i in the done_o cycle is accepted (FSM already IDLE).
- flush_i:
  - Any state → IDLE at the next edge; busy_o = 0; no done_o.
  - result_o keeps its previous value.
  - flush_i overrides a simultaneous start_i.
- done_o, illegal_o, dz_o:
  - Each is high for exactly one cycle per completed op.
  - illegal_o and dz_o are 0 whenever done_o is 0.
- Counter: log2(WIDTH)+1 bits; counts WIDTH-1 down to 0; terminates on 0. No wrap-around to a further iteration.
- Operand inputs may change freely after acceptance; the internal copies are used.

Test Plan:
- Reset/decode: hold rst_i low mid-MUL → all outputs 0 immediately. Sweep every ALUOp/funct pair → ALUCtrl_o matches the decode table; unlisted funct → 111.
- Single-cycle ops: start add with A=0x7FFFFFFF, B=1 → next cycle done_o=1, result_o=0x80000000. Then sub with A=5, B=7 → 0xFFFFFFFE. Then and/or with A=0xF0F0F0F0, B=0xFF00FF00 → 0xF000F000 / 0xFFF0FFF0.
- MUL timing: start mul with A=0xFFFFFFFF, B=3 → busy_o high exactly 32 cycles, then done_o at cycle 33 with result_o=0xFFFFFFFD. start_i pulses during busy are ignored, and no extra done_o appears.
- DIVU: A=100, B=7 → result_o=14 at cycle 33, dz_o=0. A=5, B=0 → result_o=0xFFFFFFFF, dz_o=1. With ENABLE_DIV=0, divu → 1-cycle done_o, illegal_o=1, result_o=0.
- flush: flush_i at cycle 10 of a MUL → busy_o=0 next cycle, no done_o, result_o unchanged. flush_i and start_i together in IDLE → nothing accepted.
- Back-to-back: issue a new mul (A=6, B=7) in the done_o cycle of the previous MUL → accepted; result 42 after 33 more cycles. Repeat with WIDTH=8 → latency 9 cycles, 0xFF*0xFF → 0x01.
